// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared types and constants for the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    localparam int unsigned c_default_width = 4;
    localparam int unsigned c_default_cnt_w = $clog2(c_default_width);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub_cell.sv
// ============================================================================
// Module      : addsub_cell
// Description : One-bit full adder / full subtractor selected by dec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic dec,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    // cin/cout act as borrow-in/borrow-out when dec is set
    assign cout  = dec ? ((~a & b) | (~w_axb & cin))
                       : ((a & b)  | (w_axb & cin));

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial WIDTH-bit adder/subtractor, LSB first, Start/Ready
//               handshake. Define SERIAL_ADDSUB_OVF_EN to add the Ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    output logic             Ready,
    input  logic             Dec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Done
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned    c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_part;
    logic [WIDTH-1:0]   r_result;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op;
    logic               r_cy;
    logic               r_cout;
    logic               r_done;
    logic               w_s;
    logic               w_cy_next;

    addsub_cell u_cell (
        .a    (r_sh_a[0]),
        .b    (r_sh_b[0]),
        .cin  (r_cy),
        .dec  (r_op),
        .s    (w_s),
        .cout (w_cy_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_part   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_cy     <= 1'b0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_sh_a  <= A;
                        r_sh_b  <= B;
                        r_op    <= Dec;
                        r_cy    <= Cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB
                    r_part <= {w_s, r_part[WIDTH-1:1]};
                    r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
                    r_cy   <= w_cy_next;
                    r_cnt  <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last_bit) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_result <= r_part;
                    r_cout   <= r_cy;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_cy_msb;
    logic r_ovf;

    // The last RUN cycle leaves the carry into the MSB in r_cy_msb
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cy_msb <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cy_msb <= r_cy;
            end
            if (r_state == ST_DONE) begin
                r_ovf <= r_cy_msb ^ r_cy;
            end
        end
    end

    assign Ovf = r_ovf;
`endif

    assign Ready  = (r_state == ST_IDLE);
    assign Result = r_result;
    assign Cout   = r_cout;
    assign Done   = r_done;

endmodule

`default_nettype wire
